// File: rtl/instr_sequencer.sv
// Moore control sequencer: fetch (T0-T2) and execute (T3-T6) strobes for ALU/MUL/DIV ops.
// Optional macro SEQ_MEM_WAIT_EN adds mem_rdy, which stretches T1 until memory is ready.
module instr_sequencer #(
    parameter int IR_W   = 32,
    parameter int OP_MSB = 31,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [IR_W-1:0]  ir,
`ifdef SEQ_MEM_WAIT_EN
    input  logic             mem_rdy,
`endif
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             MUL,
    output logic             DIV,
    output logic             LOin,
    output logic             HIin,
    output logic [2:0]       alu_op,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_DIV = 3'd5;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               ill_q, ill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         dec_op;
    logic               dec_ill;
    logic               unused_ir;

    // Only the opcode field matters here; the register fields go to the datapath.
    assign unused_ir = ^ir;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (ir[OP_MSB -: 5])
            5'b00011: dec_op = OP_ADD;
            5'b00100: dec_op = OP_SUB;
            5'b00101: dec_op = OP_AND;
            5'b00110: dec_op = OP_OR;
            5'b01110: dec_op = OP_MUL;
            5'b01111: dec_op = OP_DIV;
            default:  dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ill_d    = ill_q;
        cnt_d    = cnt_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        MUL      = 1'b0;
        DIV      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        alu_op   = 3'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
                if (mem_rdy) state_d = S_T2;
`else
                state_d = S_T2;
`endif
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                // IR is loaded by the end of T2, so the opcode is stable here.
                Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                op_d  = dec_op;
                ill_d = dec_ill;
                state_d = dec_ill ? S_DONE : S_T4;
            end
            S_T4: begin
                Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                alu_op = op_q;
                MUL = (op_q == OP_MUL);
                DIV = (op_q == OP_DIV);
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    LOin = 1'b1;
                    state_d = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = ill_q;
                if (!ill_q) cnt_d = cnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_cnt  = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random instructions
// compared cycle by cycle against a strobe-sequence model built from the opcode rules.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [31:0] ir;
`ifdef SEQ_MEM_WAIT_EN
    logic        mem_rdy;
`endif
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout, MUL, DIV, LOin, HIin, done, illegal;
    logic [2:0]  alu_op;
    logic [15:0] inst_cnt;
    logic [3:0]  dbg_state;

    instr_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir),
`ifdef SEQ_MEM_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .MUL(MUL), .DIV(DIV), .LOin(LOin), .HIin(HIin), .alu_op(alu_op), .done(done),
        .illegal(illegal), .inst_cnt(inst_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [25:0] M_PCOUT  = 26'd1 << 25;
    localparam logic [25:0] M_MARIN  = 26'd1 << 24;
    localparam logic [25:0] M_INCPC  = 26'd1 << 23;
    localparam logic [25:0] M_ZIN    = 26'd1 << 22;
    localparam logic [25:0] M_ZLOW   = 26'd1 << 21;
    localparam logic [25:0] M_ZHIGH  = 26'd1 << 20;
    localparam logic [25:0] M_PCIN   = 26'd1 << 19;
    localparam logic [25:0] M_READ   = 26'd1 << 18;
    localparam logic [25:0] M_MDRIN  = 26'd1 << 17;
    localparam logic [25:0] M_MDROUT = 26'd1 << 16;
    localparam logic [25:0] M_IRIN   = 26'd1 << 15;
    localparam logic [25:0] M_YIN    = 26'd1 << 14;
    localparam logic [25:0] M_GRA    = 26'd1 << 13;
    localparam logic [25:0] M_GRB    = 26'd1 << 12;
    localparam logic [25:0] M_GRC    = 26'd1 << 11;
    localparam logic [25:0] M_RIN    = 26'd1 << 10;
    localparam logic [25:0] M_ROUT   = 26'd1 << 9;
    localparam logic [25:0] M_MUL    = 26'd1 << 8;
    localparam logic [25:0] M_DIV    = 26'd1 << 7;
    localparam logic [25:0] M_LOIN   = 26'd1 << 6;
    localparam logic [25:0] M_HIIN   = 26'd1 << 5;
    localparam logic [25:0] M_DONE   = 26'd1 << 1;
    localparam logic [25:0] M_ILL    = 26'd1 << 0;

    localparam logic [31:0] IR_ADD = 32'h18918000;
    localparam logic [31:0] IR_MUL = 32'h70918000;
    localparam logic [31:0] IR_DIV = 32'h78918000;
    localparam logic [31:0] IR_BAD = 32'hF8000000;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] cnt_exp;
    logic [25:0] exp_q[$];
    logic [4:0]  legal_ops [6] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01110, 5'b01111};

    function automatic logic [25:0] obs_vec();
        return {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
                IRin, Yin, Gra, Grb, Grc, Rin, Rout, MUL, DIV, LOin, HIin, alu_op, done, illegal};
    endfunction

    // alu_op code for a legal opcode, -1 for anything not in the opcode map.
    function automatic int classify(logic [4:0] opc);
        case (opc)
            5'b00011: return 0;
            5'b00100: return 1;
            5'b00101: return 2;
            5'b00110: return 3;
            5'b01110: return 4;
            5'b01111: return 5;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [25:0] t4_vec(int cls);
        logic [25:0] v;
        v = M_GRC | M_ROUT | M_ZIN | (26'(cls) << 2);
        if (cls == 4) v = v | M_MUL;
        if (cls == 5) v = v | M_DIV;
        return v;
    endfunction

    task automatic build_seq(input logic [31:0] irv, input int wait_n);
        int cls;
        cls = classify(irv[31:27]);
        exp_q.delete();
        exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        repeat (wait_n + 1) exp_q.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_IRIN);
        exp_q.push_back(M_GRB | M_ROUT | M_YIN);
        if (cls < 0) begin
            exp_q.push_back(M_DONE | M_ILL);
        end else begin
            exp_q.push_back(t4_vec(cls));
            if (cls >= 4) begin
                exp_q.push_back(M_ZLOW | M_LOIN);
                exp_q.push_back(M_ZHIGH | M_HIIN);
            end else begin
                exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
            end
            exp_q.push_back(M_DONE);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one instruction from IDLE and checks every cycle until it is back in IDLE.
    task automatic run_instr(input logic [31:0] irv, input int wait_n, input string tag);
        int cls, lat_obs, lat_exp, i;
        logic [25:0] e;
        cls = classify(irv[31:27]);
        lat_exp = ((cls < 0) ? 4 : ((cls >= 4) ? 7 : 6)) + wait_n;
        build_seq(irv, wait_n);
        @(negedge clk);
        ir  = irv;
        run = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
        mem_rdy = (wait_n == 0);
`endif
        @(posedge clk); #1;
        run = 1'b0;
        lat_obs = -1;
        i = 0;
        while (exp_q.size() > 0) begin
`ifdef SEQ_MEM_WAIT_EN
            mem_rdy = (i >= wait_n + 1);
`endif
            e = exp_q.pop_front();
            check($sformatf("%s cyc%0d", tag, i), 32'(obs_vec()), 32'(e));
            if (done && lat_obs < 0) lat_obs = i;
            i++;
            @(posedge clk); #1;
        end
        if (cls >= 0) cnt_exp++;
        check({tag, " idle"}, 32'(obs_vec()), 32'd0);
        check({tag, " inst_cnt"}, 32'(inst_cnt), 32'(cnt_exp));
        check({tag, " latency"}, 32'(lat_obs), 32'(lat_exp));
    endtask

    initial begin
        logic [25:0] seq8 [8];
        logic [4:0]  opc;
        logic [31:0] irv;
        int          dones, wn;

        clr = 1'b1; run = 1'b0; ir = 32'd0;
`ifdef SEQ_MEM_WAIT_EN
        mem_rdy = 1'b1;
`endif
        cnt_exp = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        run = 1'b1;
        #1;
        check("reset outputs", 32'(obs_vec()), 32'd0);
        check("reset inst_cnt", 32'(inst_cnt), 32'd0);
        @(negedge clk);
        run = 1'b0;
        clr = 1'b0;

        run_instr(IR_ADD, 0, "add");
        run_instr(IR_MUL, 0, "mul");
        run_instr(IR_BAD, 0, "illegal");

        // Asynchronous clear in the middle of T4 of a DIV.
        @(negedge clk);
        ir = IR_DIV; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("div t4 before clr", 32'(obs_vec()), 32'(t4_vec(5)));
        #2 clr = 1'b1;
        #1;
        cnt_exp = 16'd0;
        check("clr outputs", 32'(obs_vec()), 32'd0);
        check("clr inst_cnt", 32'(inst_cnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
            check($sformatf("after clr idle%0d", k), 32'(obs_vec()), 32'd0);
        end
        check("after clr dones", 32'(dones), 32'd0);
        run_instr(IR_ADD, 0, "restart add");

        // run held high: two instructions, each separated by one IDLE cycle.
        build_seq(IR_ADD, 0);
        for (int k = 0; k < 7; k++) seq8[k] = exp_q[k];
        seq8[7] = 26'd0;
        @(negedge clk);
        ir = IR_ADD; run = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("held run cyc%0d", k), 32'(obs_vec()),
                  32'((k < 16) ? seq8[k % 8] : 26'd0));
            if (done) dones++;
            if (k == 15) run = 1'b0;
            @(posedge clk); #1;
        end
        cnt_exp = cnt_exp + 16'd2;
        check("held run dones", 32'(dones), 32'd2);
        check("held run inst_cnt", 32'(inst_cnt), 32'(cnt_exp));

`ifdef SEQ_MEM_WAIT_EN
        run_instr(IR_ADD, 3, "mem wait add");
`endif

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) opc = 5'($urandom_range(0, 31));
            else                           opc = legal_ops[$urandom_range(0, 5)];
            irv = {opc, 27'($urandom)};
`ifdef SEQ_MEM_WAIT_EN
            wn = $urandom_range(0, 2);
`else
            wn = 0;
`endif
            run_instr(irv, wn, $sformatf("rand%0d op%b", n, opc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
